// File: rtl/wb_rr_arbiter_2m.sv
// Two-master, one-slave Wishbone round-robin arbiter placed in front of the
// SRAM bridge. A grant is registered and held for the whole CYC of the granted
// master. An optional watchdog turns a hung access into a one-cycle ERR, then
// revokes the grant.
module wb_rr_arbiter_2m #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int TIMEOUT       = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    // master 0
    input  logic                      m0_cyc_i,
    input  logic                      m0_stb_i,
    input  logic                      m0_we_i,
    input  logic [ADDRESS_WIDTH-1:0]  m0_adr_i,
    input  logic [DATA_WIDTH-1:0]     m0_dat_w_i,
    input  logic [DATA_WIDTH/8-1:0]   m0_sel_i,
    output logic [DATA_WIDTH-1:0]     m0_dat_r_o,
    output logic                      m0_ack_o,
    output logic                      m0_err_o,
    // master 1
    input  logic                      m1_cyc_i,
    input  logic                      m1_stb_i,
    input  logic                      m1_we_i,
    input  logic [ADDRESS_WIDTH-1:0]  m1_adr_i,
    input  logic [DATA_WIDTH-1:0]     m1_dat_w_i,
    input  logic [DATA_WIDTH/8-1:0]   m1_sel_i,
    output logic [DATA_WIDTH-1:0]     m1_dat_r_o,
    output logic                      m1_ack_o,
    output logic                      m1_err_o,
    // slave (SRAM bridge)
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic                      s_we_o,
    output logic [ADDRESS_WIDTH-1:0]  s_adr_o,
    output logic [DATA_WIDTH-1:0]     s_dat_w_o,
    output logic [DATA_WIDTH/8-1:0]   s_sel_o,
    input  logic [DATA_WIDTH-1:0]     s_dat_r_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i
);

    // A zero TIMEOUT still needs a legal 1-bit counter; it simply never counts.
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           last_q, last_d;     // master that won the most recent grant
    logic           blk0_q, blk0_d;     // master 0 timed out and has not dropped CYC yet
    logic           blk1_q, blk1_d;
    logic [WDW-1:0] wdog_q, wdog_d;

    logic req0, req1;
    logic gnt_cyc, gnt_stb;
    logic wd_inc, wd_fire;

    // Read data needs no routing: both masters see the bridge data, and only
    // the granted one gets the ACK that qualifies it.
    assign m0_dat_r_o = s_dat_r_i;
    assign m1_dat_r_o = s_dat_r_i;

    // A blocked master is ignored until it acknowledges the ERR by dropping CYC.
    assign req0 = m0_cyc_i & ~blk0_q;
    assign req1 = m1_cyc_i & ~blk1_q;

    // Select the CYC/STB of whichever master currently holds the grant.
    always_comb begin
        gnt_cyc = 1'b0;
        gnt_stb = 1'b0;
        case (state_q)
            GNT0: begin
                gnt_cyc = m0_cyc_i;
                gnt_stb = m0_stb_i;
            end
            GNT1: begin
                gnt_cyc = m1_cyc_i;
                gnt_stb = m1_stb_i;
            end
            default: ;
        endcase
    end

    // An ACK or ERR from the bridge in the same cycle always beats the watchdog.
    assign wd_inc  = (state_q != IDLE) & gnt_cyc & gnt_stb & ~s_ack_i & ~s_err_i;
    assign wd_fire = (TIMEOUT > 0) && wd_inc && (wdog_q == WD_LAST);

    // State register and the arbiter's control registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            blk0_q  <= 1'b0;
            blk1_q  <= 1'b0;
            wdog_q  <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            blk0_q  <= blk0_d;
            blk1_q  <= blk1_d;
            wdog_q  <= wdog_d;
        end
    end

    // Next-state: round-robin choice in IDLE, release on CYC drop or timeout.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || last_q)) begin
                    state_d = GNT0;
                    last_d  = 1'b0;
                end else if (req1) begin
                    state_d = GNT1;
                    last_d  = 1'b1;
                end
            end
            GNT0: if (!m0_cyc_i || wd_fire) state_d = IDLE;
            GNT1: if (!m1_cyc_i || wd_fire) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Watchdog counter and block flags.
    always_comb begin
        blk0_d = blk0_q;
        blk1_d = blk1_q;
        if (state_q == GNT0 && wd_fire) begin
            blk0_d = 1'b1;
        end else if (!m0_cyc_i) begin
            blk0_d = 1'b0;
        end
        if (state_q == GNT1 && wd_fire) begin
            blk1_d = 1'b1;
        end else if (!m1_cyc_i) begin
            blk1_d = 1'b0;
        end
        if ((TIMEOUT > 0) && wd_inc && !wd_fire) begin
            wdog_d = wdog_q + WDW'(1);
        end else begin
            wdog_d = '0;
        end
    end

    // Output mux: slave side follows the granted master; responses go back to it only.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_adr_o   = '0;
        s_dat_w_o = '0;
        s_sel_o   = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        case (state_q)
            GNT0: begin
                s_cyc_o   = m0_cyc_i;
                s_stb_o   = m0_stb_i;
                s_we_o    = m0_we_i;
                s_adr_o   = m0_adr_i;
                s_dat_w_o = m0_dat_w_i;
                s_sel_o   = m0_sel_i;
                m0_ack_o  = s_ack_i;
                m0_err_o  = s_err_i | wd_fire;
            end
            GNT1: begin
                s_cyc_o   = m1_cyc_i;
                s_stb_o   = m1_stb_i;
                s_we_o    = m1_we_i;
                s_adr_o   = m1_adr_i;
                s_dat_w_o = m1_dat_w_i;
                s_sel_o   = m1_sel_i;
                m1_ack_o  = s_ack_i;
                m1_err_o  = s_err_i | wd_fire;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter_2m.sv
// Directed bench for wb_rr_arbiter_2m with a two-cycle SRAM bridge model.
module tb_wb_rr_arbiter_2m;

    logic        clk = 1'b0;
    logic        rstn;
    logic        m0_cyc, m0_stb, m0_we;
    logic [31:0] m0_adr, m0_dat_w;
    logic [3:0]  m0_sel;
    logic [31:0] m0_dat_r;
    logic        m0_ack, m0_err;
    logic        m1_cyc, m1_stb, m1_we;
    logic [31:0] m1_adr, m1_dat_w;
    logic [3:0]  m1_sel;
    logic [31:0] m1_dat_r;
    logic        m1_ack, m1_err;
    logic        s_cyc, s_stb, s_we;
    logic [31:0] s_adr, s_dat_w, s_dat_r;
    logic [3:0]  s_sel;
    logic        s_ack, s_err;

    // bridge model controls
    logic        auto_slv;
    logic        slv_en;
    logic        man_ack, man_err;
    logic        slv_ack = 1'b0;
    logic [1:0]  slv_cnt = 2'd0;
    logic [31:0] slv_rdata = 32'd0;
    logic [31:0] mem [0:15];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wb_rr_arbiter_2m #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4)) dut (
        .clk(clk), .rstn(rstn),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
        .m0_dat_w_i(m0_dat_w), .m0_sel_i(m0_sel), .m0_dat_r_o(m0_dat_r),
        .m0_ack_o(m0_ack), .m0_err_o(m0_err),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
        .m1_dat_w_i(m1_dat_w), .m1_sel_i(m1_sel), .m1_dat_r_o(m1_dat_r),
        .m1_ack_o(m1_ack), .m1_err_o(m1_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
        .s_dat_w_o(s_dat_w), .s_sel_o(s_sel), .s_dat_r_i(s_dat_r),
        .s_ack_i(s_ack), .s_err_i(s_err)
    );

    assign s_ack   = auto_slv ? slv_ack : man_ack;
    assign s_err   = auto_slv ? 1'b0 : man_err;
    assign s_dat_r = slv_rdata;

    // Two-cycle bridge: STB seen in cycle k is ACKed in cycle k+2.
    always @(posedge clk) begin
        if (s_cyc && s_stb && slv_en && !slv_ack) begin
            if (slv_cnt == 2'd1) begin
                slv_ack   <= 1'b1;
                slv_cnt   <= 2'd0;
                slv_rdata <= mem[s_adr[5:2]];
                if (s_we) mem[s_adr[5:2]] <= s_dat_w;
            end else begin
                slv_cnt <= slv_cnt + 2'd1;
            end
        end else begin
            slv_ack <= 1'b0;
            slv_cnt <= 2'd0;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n;
        int exp_m;
        rstn = 1'b0;
        m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = 0; m0_dat_w = 0; m0_sel = 0;
        m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = 0; m1_dat_w = 0; m1_sel = 0;
        auto_slv = 1'b1; slv_en = 1'b1; man_ack = 1'b0; man_err = 1'b0;

        // ---------------- reset state
        step(); step();
        chk("rst_s_cyc", s_cyc, 0);
        chk("rst_m0_ack", m0_ack, 0);
        chk("rst_m1_err", m1_err, 0);

        // ---------------- single master: write then read in one CYC
        step();
        rstn = 1'b1;
        m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 32'h10; m0_dat_w = 32'hA5A5A5A5; m0_sel = 4'hF;
        #1 chk("wr_idle_s_cyc", s_cyc, 0);
        step();
        chk("wr_s_cyc", s_cyc, 1);
        chk("wr_s_we", s_we, 1);
        chk("wr_s_adr", s_adr, 32'h10);
        chk("wr_s_dat_w", s_dat_w, 32'hA5A5A5A5);
        chk("wr_s_sel", s_sel, 4'hF);
        chk("wr_m0_ack_early", m0_ack, 0);
        step();
        step();
        chk("wr_m0_ack", m0_ack, 1);
        chk("wr_m1_ack", m1_ack, 0);
        step();
        m0_we = 0; m0_dat_w = 0;
        #1 chk("rd_s_we", s_we, 0);
        step();
        chk("rd_m0_ack_early", m0_ack, 0);
        step();
        chk("rd_m0_ack", m0_ack, 1);
        chk("rd_m0_dat_r", m0_dat_r, 32'hA5A5A5A5);
        chk("rd_m1_dat_r", m1_dat_r, 32'hA5A5A5A5);
        chk("rd_m1_ack", m1_ack, 0);
        step();
        m0_cyc = 0; m0_stb = 0;
        #1 chk("drop_s_cyc", s_cyc, 0);
        step();

        // ---------------- tie after reset
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20; m1_sel = 4'hF;
        step();
        chk("tie_s_cyc", s_cyc, 1);
        chk("tie_s_adr_m0", s_adr, 32'h10);
        step();
        step();
        chk("tie_m0_ack", m0_ack, 1);
        chk("tie_m1_ack", m1_ack, 0);
        step();
        m0_cyc = 0; m0_stb = 0;
        step();
        chk("sw_idle_s_cyc", s_cyc, 0);
        step();
        chk("sw_s_cyc", s_cyc, 1);
        chk("sw_s_adr_m1", s_adr, 32'h20);
        step();
        step();
        chk("sw_m1_ack", m1_ack, 1);
        chk("sw_m0_ack", m0_ack, 0);
        step();
        m1_cyc = 0; m1_stb = 0;
        step();
        m0_cyc = 1; m0_stb = 1;
        m1_cyc = 1; m1_stb = 1;

        // ---------------- fairness: 4 reads each, both always requesting
        exp_m = 0;
        for (int k = 0; k < 8; k++) begin
            n = 0;
            step();
            while (!s_cyc && n < 6) begin
                step();
                n++;
            end
            chk("fair_gnt_adr", s_adr, (exp_m == 1) ? 32'h20 : 32'h10);
            n = 0;
            while (!((exp_m == 1) ? m1_ack : m0_ack) && n < 6) begin
                step();
                n++;
            end
            chk("fair_ack", (exp_m == 1) ? m1_ack : m0_ack, 1);
            chk("fair_other_ack", (exp_m == 1) ? m0_ack : m1_ack, 0);
            step();
            if (exp_m == 1) begin m1_cyc = 0; m1_stb = 0; end
            else begin m0_cyc = 0; m0_stb = 0; end
            step();
            if (exp_m == 1) begin m1_cyc = 1; m1_stb = 1; end
            else begin m0_cyc = 1; m0_stb = 1; end
            exp_m = 1 - exp_m;
        end
        m0_cyc = 0; m0_stb = 0;
        m1_cyc = 0; m1_stb = 0;

        // ---------------- watchdog: slave never answers
        slv_en = 1'b0;
        step();
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20;
        #1 chk("wd_idle_s_cyc", s_cyc, 0);
        step();
        chk("wd_s_cyc", s_cyc, 1);
        chk("wd_err_n", m1_err, 0);
        step();
        chk("wd_err_n1", m1_err, 0);
        step();
        chk("wd_err_n2", m1_err, 0);
        step();
        chk("wd_err_n3", m1_err, 1);
        chk("wd_m0_err", m0_err, 0);
        chk("wd_m1_ack", m1_ack, 0);
        step();
        chk("wd_s_cyc_n4", s_cyc, 0);
        chk("wd_err_n4", m1_err, 0);
        step();
        chk("wd_blocked_s_cyc", s_cyc, 0);
        step();
        m1_cyc = 0; m1_stb = 0;
        #1 chk("wd_drop_s_cyc", s_cyc, 0);
        step();
        m1_cyc = 1; m1_stb = 1;
        #1 chk("wd_reraise_idle", s_cyc, 0);
        step();
        chk("wd_regrant_s_cyc", s_cyc, 1);
        chk("wd_regrant_adr", s_adr, 32'h20);
        step();
        m1_cyc = 0; m1_stb = 0;

        // ---------------- ACK exactly on the timeout cycle
        auto_slv = 1'b0;
        step();
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
        step();
        chk("ato_s_cyc", s_cyc, 1);
        step();
        step();
        step();
        man_ack = 1'b1;
        #1 chk("ato_m0_ack", m0_ack, 1);
        chk("ato_m0_err", m0_err, 0);
        chk("ato_m1_ack", m1_ack, 0);
        step();
        man_ack = 1'b0; man_err = 1'b1;
        #1 chk("ato_kept_s_cyc", s_cyc, 1);
        chk("serr_m0_err", m0_err, 1);
        chk("serr_m1_err", m1_err, 0);
        chk("serr_m0_ack", m0_ack, 0);
        step();
        man_err = 1'b0;
        m0_cyc = 0; m0_stb = 0;
        auto_slv = 1'b1; slv_en = 1'b1;
        step();

        // ---------------- reset in the middle of an m1 read
        m1_cyc = 1; m1_stb = 1; m1_adr = 32'h20; m1_sel = 4'hF;
        step();
        chk("mr_s_cyc", s_cyc, 1);
        chk("mr_s_adr", s_adr, 32'h20);
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        m0_cyc = 1; m0_stb = 1; m0_adr = 32'h10;
        #1 chk("mr_s_cyc_0", s_cyc, 0);
        chk("mr_s_stb_0", s_stb, 0);
        chk("mr_s_adr_0", s_adr, 0);
        chk("mr_s_sel_0", s_sel, 0);
        chk("mr_late_ack_seen", s_ack, 1);
        chk("mr_m1_ack_0", m1_ack, 0);
        chk("mr_m0_ack_0", m0_ack, 0);
        chk("mr_m1_err_0", m1_err, 0);
        step();
        chk("mr_tie_s_cyc", s_cyc, 1);
        chk("mr_tie_adr_m0", s_adr, 32'h10);
        m0_cyc = 0; m0_stb = 0;
        m1_cyc = 0; m1_stb = 0;
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
